// File: rtl/ahb_pkg.sv
// Shared AHB-Lite codes, sequencer state encoding and address helpers.
package ahb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BEATS  = 4;
    localparam int LINE_W = DATA_W * BEATS;

    // Highest addr_cnt value of an INCR4 burst (beats - 1)
    localparam logic [2:0] LAST_BURST_CNT = 3'(BEATS - 1);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    // Sequencer states
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ADDR      = 2'd1;
    localparam logic [1:0] ST_LAST_DATA = 2'd2;
    localparam logic [1:0] ST_ERR2      = 2'd3;

    // Opcodes the upstream decoder turns into ENABLE/BURST/WRITE/BUSY
    typedef enum logic [5:0] {
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011,
        OP_LH    = 6'b100001,
        OP_LB    = 6'b100000,
        OP_RTYPE = 6'b000000
    } opcode_e;

    // Word-align singles; line-align bursts so INCR4 never crosses 1KB
    function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a,
                                                     input logic burst);
        return burst ? {a[ADDR_W-1:4], 4'h0} : {a[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ahb_master_sequencer_if.sv
// Command side and AHB-Lite bus side of the sequencer bundled in one interface.
interface ahb_master_sequencer_if;
    import ahb_pkg::*;

    logic              CMD_VALID;
    logic              CMD_READY;
    logic              CMD_BURST;
    logic              CMD_WRITE;
    logic [ADDR_W-1:0] CMD_ADDR;
    logic [LINE_W-1:0] CMD_WDATA;
    logic              BUSY_IN;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [DATA_W-1:0] HWDATA;
    logic [DATA_W-1:0] HRDATA;
    logic              HREADY;
    logic              HRESP;
    logic [LINE_W-1:0] RDATA;
    logic              DONE;
    logic              ERR;

    modport master (
        input  CMD_VALID, CMD_BURST, CMD_WRITE, CMD_ADDR, CMD_WDATA, BUSY_IN,
               HRDATA, HREADY, HRESP,
        output CMD_READY, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
               RDATA, DONE, ERR
    );

    modport slave (
        output CMD_VALID, CMD_BURST, CMD_WRITE, CMD_ADDR, CMD_WDATA, BUSY_IN,
               HRDATA, HREADY, HRESP,
        input  CMD_READY, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
               RDATA, DONE, ERR
    );

endinterface

// File: rtl/ahb_line_buffer.sv
// Write-line latch and read-line capture, both indexed by the data-phase beat.
module ahb_line_buffer
    import ahb_pkg::*;
(
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              i_load,
    input  logic [LINE_W-1:0] i_wline,
    input  logic              i_cap,
    input  logic [2:0]        i_idx,
    input  logic [DATA_W-1:0] i_rbeat,
    output logic [DATA_W-1:0] o_wbeat,
    output logic [LINE_W-1:0] o_rline
);

    logic [BEATS-1:0][DATA_W-1:0] r_wline;
    logic [BEATS-1:0][DATA_W-1:0] r_rline;

    // Latch the write line on command accept; capture read beats as they complete
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_wline <= '0;
            r_rline <= '0;
        end else begin
            if (i_load) r_wline <= i_wline;
            // idx reaches BEATS only after the final beat; never write past the line
            if (i_cap && !i_idx[2]) r_rline[i_idx[1:0]] <= i_rbeat;
        end
    end

    assign o_wbeat = r_wline[i_idx[1:0]];
    assign o_rline = r_rline;

endmodule

// File: rtl/ahb_master_sequencer.sv
// AHB-Lite master sequencer: SINGLE or INCR4 word transfers with wait, BUSY
// and two-cycle ERROR handling.
//
//   state     | meaning
//   IDLE      | ready for a command, no address phase on the bus
//   ADDR      | issuing NONSEQ/SEQ/BUSY address phases
//   LAST_DATA | last address accepted, waiting for its data phase
//   ERR2      | second cycle of an ERROR response
module ahb_master_sequencer
    import ahb_pkg::*;
(
    input  logic                   HCLK,
    input  logic                   HRESET,
    ahb_master_sequencer_if.master bus
);

    logic [1:0]        r_state;
    logic              r_burst;
    logic              r_write;
    logic              r_dp_valid;
    logic              r_done;
    logic              r_err;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_haddr;
    logic [1:0]        r_htrans;
    logic [2:0]        r_addr_cnt;
    logic [2:0]        r_data_cnt;

    logic              w_accept;
    logic              w_in_xfer;
    logic              w_addr_acc;
    logic              w_last_addr;
    logic              w_err_start;
    logic              w_data_ok;
    logic [2:0]        w_addr_cnt_nxt;
    logic [DATA_W-1:0] w_wbeat;
    logic [LINE_W-1:0] w_rline;

    assign w_accept       = (r_state == ST_IDLE) && bus.CMD_VALID;
    assign w_in_xfer      = (r_state == ST_ADDR) || (r_state == ST_LAST_DATA);
    assign w_addr_acc     = (r_state == ST_ADDR) && bus.HREADY &&
                            ((r_htrans == HTRANS_NONSEQ) || (r_htrans == HTRANS_SEQ));
    assign w_addr_cnt_nxt = r_addr_cnt + 3'd1;
    assign w_last_addr    = (r_addr_cnt == (r_burst ? LAST_BURST_CNT : 3'd0));
    assign w_err_start    = w_in_xfer && r_dp_valid && bus.HRESP && !bus.HREADY;
    assign w_data_ok      = w_in_xfer && r_dp_valid && bus.HREADY && !bus.HRESP;

    ahb_line_buffer u_line (
        .HCLK    (HCLK),
        .HRESET  (HRESET),
        .i_load  (w_accept),
        .i_wline (bus.CMD_WDATA),
        .i_cap   (w_data_ok && !r_write),
        .i_idx   (r_data_cnt),
        .i_rbeat (bus.HRDATA),
        .o_wbeat (w_wbeat),
        .o_rline (w_rline)
    );

    // Sequencer FSM, address-phase generation and data-phase tracking
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state    <= ST_IDLE;
            r_burst    <= 1'b0;
            r_write    <= 1'b0;
            r_dp_valid <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_base     <= '0;
            r_haddr    <= '0;
            r_htrans   <= HTRANS_IDLE;
            r_addr_cnt <= '0;
            r_data_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;

            if (w_data_ok) r_data_cnt <= r_data_cnt + 3'd1;

            // The data phase that follows is real only for an accepted NONSEQ/SEQ
            if (w_err_start)      r_dp_valid <= 1'b0;
            else if (bus.HREADY)  r_dp_valid <= w_addr_acc;

            case (r_state)
                ST_IDLE: begin
                    if (bus.CMD_VALID) begin
                        r_burst    <= bus.CMD_BURST;
                        r_write    <= bus.CMD_WRITE;
                        r_base     <= align_addr(bus.CMD_ADDR, bus.CMD_BURST);
                        r_haddr    <= align_addr(bus.CMD_ADDR, bus.CMD_BURST);
                        r_htrans   <= HTRANS_NONSEQ;
                        r_addr_cnt <= '0;
                        r_data_cnt <= '0;
                        r_state    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (w_err_start) begin
                        r_htrans <= HTRANS_IDLE;
                        r_state  <= ST_ERR2;
                    end else if (bus.HREADY) begin
                        if (w_addr_acc && w_last_addr) begin
                            r_addr_cnt <= w_addr_cnt_nxt;
                            r_htrans   <= HTRANS_IDLE;
                            r_state    <= ST_LAST_DATA;
                        end else begin
                            // A BUSY slot keeps the next-beat address and count
                            if (w_addr_acc) begin
                                r_addr_cnt <= w_addr_cnt_nxt;
                                r_haddr    <= r_base + ADDR_W'({w_addr_cnt_nxt, 2'b00});
                            end
                            r_htrans <= (bus.BUSY_IN && r_burst) ? HTRANS_BUSY : HTRANS_SEQ;
                        end
                    end
                end
                ST_LAST_DATA: begin
                    if (w_err_start) begin
                        r_htrans <= HTRANS_IDLE;
                        r_state  <= ST_ERR2;
                    end else if (w_data_ok) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    if (bus.HREADY) begin
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.CMD_READY = (r_state == ST_IDLE);
    assign bus.HADDR     = r_haddr;
    assign bus.HTRANS    = r_htrans;
    assign bus.HWRITE    = r_write;
    assign bus.HSIZE     = HSIZE_WORD;
    assign bus.HBURST    = r_burst ? HBURST_INCR4 : HBURST_SINGLE;
    assign bus.HWDATA    = (r_dp_valid && r_write) ? w_wbeat : '0;
    assign bus.RDATA     = w_rline;
    assign bus.DONE      = r_done;
    assign bus.ERR       = r_err;

endmodule

// File: tb/tb_ahb_master_sequencer.sv
// Directed bench for ahb_master_sequencer; inputs driven and outputs sampled on
// the falling edge, cycle n means the interval after the n-th edge past accept.
module tb_ahb_master_sequencer;
    import ahb_pkg::*;

    logic HCLK   = 1'b0;
    logic HRESET = 1'b1;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    always #5 HCLK = ~HCLK;

    ahb_master_sequencer_if bus_if ();

    ahb_master_sequencer dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus_if)
    );

    task automatic expect_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        @(negedge HCLK);
    endtask

    // Present a command for one edge; returns in cycle 1
    task automatic issue(input logic burst, input logic write,
                         input logic [31:0] addr, input logic [127:0] wdata);
        expect_eq("cmd_ready_before_issue", bus_if.CMD_READY, 1'b1);
        bus_if.CMD_VALID = 1'b1;
        bus_if.CMD_BURST = burst;
        bus_if.CMD_WRITE = write;
        bus_if.CMD_ADDR  = addr;
        bus_if.CMD_WDATA = wdata;
        step();
        bus_if.CMD_VALID = 1'b0;
        bus_if.CMD_WDATA = '0;
    endtask

    initial begin
        bus_if.CMD_VALID = 1'b0;
        bus_if.CMD_BURST = 1'b0;
        bus_if.CMD_WRITE = 1'b0;
        bus_if.CMD_ADDR  = '0;
        bus_if.CMD_WDATA = '0;
        bus_if.BUSY_IN   = 1'b0;
        bus_if.HRDATA    = '0;
        bus_if.HREADY    = 1'b1;
        bus_if.HRESP     = 1'b0;

        // Reset state
        repeat (2) step();
        expect_eq("rst_htrans", bus_if.HTRANS, HTRANS_IDLE);
        expect_eq("rst_haddr",  bus_if.HADDR, 32'h0);
        expect_eq("rst_hwdata", bus_if.HWDATA, 32'h0);
        expect_eq("rst_rdata",  bus_if.RDATA, 128'h0);
        expect_eq("rst_hwrite", bus_if.HWRITE, 1'b0);
        expect_eq("rst_hburst", bus_if.HBURST, 3'b000);
        expect_eq("rst_hsize",  bus_if.HSIZE, 3'b010);
        expect_eq("rst_done",   {bus_if.DONE, bus_if.ERR}, 2'b00);
        expect_eq("rst_ready",  bus_if.CMD_READY, 1'b1);
        HRESET = 1'b0;
        step();

        // SINGLE write to 0x100
        issue(1'b0, 1'b1, 32'h100,
              {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF});
        expect_eq("t1_c1_htrans", bus_if.HTRANS, HTRANS_NONSEQ);
        expect_eq("t1_c1_haddr",  bus_if.HADDR, 32'h100);
        expect_eq("t1_c1_hwrite", bus_if.HWRITE, 1'b1);
        expect_eq("t1_c1_hburst", bus_if.HBURST, 3'b000);
        expect_eq("t1_c1_ready",  bus_if.CMD_READY, 1'b0);
        step();
        expect_eq("t1_c2_htrans", bus_if.HTRANS, HTRANS_IDLE);
        expect_eq("t1_c2_hwdata", bus_if.HWDATA, 32'hDEADBEEF);
        expect_eq("t1_c2_done",   bus_if.DONE, 1'b0);
        step();
        expect_eq("t1_c3_done_err", {bus_if.DONE, bus_if.ERR}, 2'b10);

        // INCR4 read from 0x204, accepted in the same cycle DONE is high
        issue(1'b1, 1'b0, 32'h204, 128'h0);
        for (int c = 1; c <= 5; c++) begin
            expect_eq($sformatf("t2_c%0d_htrans", c), bus_if.HTRANS,
                      (c == 1) ? HTRANS_NONSEQ : (c == 5) ? HTRANS_IDLE : HTRANS_SEQ);
            if (c <= 4)
                expect_eq($sformatf("t2_c%0d_haddr", c), bus_if.HADDR, 32'h200 + 32'(4 * (c - 1)));
            expect_eq($sformatf("t2_c%0d_done", c), bus_if.DONE, 1'b0);
            bus_if.HRDATA = (c >= 2) ? 32'(c - 1) : 32'h0;
            step();
        end
        expect_eq("t2_c6_done_err", {bus_if.DONE, bus_if.ERR}, 2'b10);
        expect_eq("t2_c6_rdata", bus_if.RDATA, 128'h00000004_00000003_00000002_00000001);
        bus_if.HRDATA = '0;
        step();
        expect_eq("t2_c7_done", bus_if.DONE, 1'b0);

        // INCR4 write to 0x500 with two wait states on beat 1
        issue(1'b1, 1'b1, 32'h500, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        expect_eq("t3_c1_htrans", bus_if.HTRANS, HTRANS_NONSEQ);
        expect_eq("t3_c1_hburst", bus_if.HBURST, 3'b011);
        step();
        for (int c = 2; c <= 4; c++) begin
            expect_eq($sformatf("t3_c%0d_htrans", c), bus_if.HTRANS, HTRANS_SEQ);
            expect_eq($sformatf("t3_c%0d_haddr", c), bus_if.HADDR, 32'h504);
            expect_eq($sformatf("t3_c%0d_hwdata", c), bus_if.HWDATA, 32'hA0);
            bus_if.HREADY = (c == 4);
            step();
        end
        expect_eq("t3_c5_haddr",  bus_if.HADDR, 32'h508);
        expect_eq("t3_c5_hwdata", bus_if.HWDATA, 32'hA1);
        step();
        expect_eq("t3_c6_haddr",  bus_if.HADDR, 32'h50C);
        expect_eq("t3_c6_hwdata", bus_if.HWDATA, 32'hA2);
        step();
        expect_eq("t3_c7_htrans", bus_if.HTRANS, HTRANS_IDLE);
        expect_eq("t3_c7_hwdata", bus_if.HWDATA, 32'hA3);
        expect_eq("t3_c7_done",   bus_if.DONE, 1'b0);
        step();
        expect_eq("t3_c8_done_err", {bus_if.DONE, bus_if.ERR}, 2'b10);

        // INCR4 read from 0x30A with one BUSY slot after NONSEQ
        issue(1'b1, 1'b0, 32'h30A, 128'h0);
        expect_eq("t4_c1_haddr", bus_if.HADDR, 32'h300);
        bus_if.BUSY_IN = 1'b1;
        step();
        expect_eq("t4_c2_htrans", bus_if.HTRANS, HTRANS_BUSY);
        expect_eq("t4_c2_haddr",  bus_if.HADDR, 32'h304);
        bus_if.BUSY_IN = 1'b0;
        bus_if.HRDATA  = 32'hB0;
        step();
        expect_eq("t4_c3_htrans", bus_if.HTRANS, HTRANS_SEQ);
        expect_eq("t4_c3_haddr",  bus_if.HADDR, 32'h304);
        bus_if.HRDATA = 32'h0BADBAD0;
        step();
        expect_eq("t4_c4_haddr", bus_if.HADDR, 32'h308);
        bus_if.HRDATA = 32'hB1;
        step();
        expect_eq("t4_c5_haddr", bus_if.HADDR, 32'h30C);
        bus_if.HRDATA = 32'hB2;
        step();
        expect_eq("t4_c6_htrans", bus_if.HTRANS, HTRANS_IDLE);
        expect_eq("t4_c6_done",   bus_if.DONE, 1'b0);
        bus_if.HRDATA = 32'hB3;
        step();
        expect_eq("t4_c7_done_err", {bus_if.DONE, bus_if.ERR}, 2'b10);
        expect_eq("t4_c7_rdata", bus_if.RDATA, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
        bus_if.HRDATA = '0;
        step();

        // INCR4 write to 0x400, ERROR while 0x40C is pending
        issue(1'b1, 1'b1, 32'h400, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
        step();
        step();
        step();
        expect_eq("t5_c4_haddr", bus_if.HADDR, 32'h40C);
        expect_eq("t5_c4_hwdata", bus_if.HWDATA, 32'hC2);
        bus_if.HREADY = 1'b0;
        bus_if.HRESP  = 1'b1;
        step();
        expect_eq("t5_c5_htrans", bus_if.HTRANS, HTRANS_IDLE);
        expect_eq("t5_c5_done",   bus_if.DONE, 1'b0);
        bus_if.HREADY = 1'b1;
        step();
        expect_eq("t5_c6_done_err", {bus_if.DONE, bus_if.ERR}, 2'b11);
        expect_eq("t5_c6_rdata_kept", bus_if.RDATA, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
        bus_if.HRESP = 1'b0;
        step();
        expect_eq("t5_c7_done_err", {bus_if.DONE, bus_if.ERR}, 2'b00);
        expect_eq("t5_c7_htrans", bus_if.HTRANS, HTRANS_IDLE);

        // Reset in the middle of an INCR4 read, then a normal SINGLE read
        issue(1'b1, 1'b0, 32'h600, 128'h0);
        step();
        expect_eq("t6_c2_haddr", bus_if.HADDR, 32'h604);
        HRESET = 1'b1;
        step();
        HRESET = 1'b0;
        expect_eq("t6_htrans", bus_if.HTRANS, HTRANS_IDLE);
        expect_eq("t6_ready",  bus_if.CMD_READY, 1'b1);
        expect_eq("t6_done",   bus_if.DONE, 1'b0);
        expect_eq("t6_rdata",  bus_if.RDATA, 128'h0);
        step();
        expect_eq("t6_idle_done", bus_if.DONE, 1'b0);
        issue(1'b0, 1'b0, 32'h107, 128'h0);
        expect_eq("t7_c1_htrans", bus_if.HTRANS, HTRANS_NONSEQ);
        expect_eq("t7_c1_haddr",  bus_if.HADDR, 32'h104);
        expect_eq("t7_c1_hwrite", bus_if.HWRITE, 1'b0);
        step();
        expect_eq("t7_c2_htrans", bus_if.HTRANS, HTRANS_IDLE);
        bus_if.HRDATA = 32'hCAFEF00D;
        step();
        expect_eq("t7_c3_done_err", {bus_if.DONE, bus_if.ERR}, 2'b10);
        expect_eq("t7_c3_rdata", bus_if.RDATA, {96'h0, 32'hCAFEF00D});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ahb_master_sequencer.md
Name: ahb_master_sequencer

Overview:
Sequences AHB-Lite master transfers from the decoded MIPS load/store command (ENABLE/BURST/WRITE/BUSY) into a pipelined address/data-phase bus protocol. It issues either a SINGLE word transfer or a fixed INCR4 cache-line burst and buffers the write and read lines. It handles slave wait states, master BUSY insertion and two-cycle ERROR responses. It sits between the opcode decoder and the AHB interconnect.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, bus data width; fixed, word transfers only
BEATS, 4, burst length for INCR4; fixed

Ports:
HCLK  in  1  sole clock, rising edge
HRESET  in  1  synchronous, active-high reset
CMD_VALID  in  1  command present; equals decoder ENABLE
CMD_READY  out  1  sequencer can accept a command; high only in IDLE
CMD_BURST  in  1  1 = INCR4, 0 = SINGLE
CMD_WRITE  in  1  1 = write, 0 = read
CMD_ADDR  in  32  start byte address
CMD_WDATA  in  128  write line; beat i uses bits [32i+31:32i]
BUSY_IN  in  1  decoder BUSY; requests an HTRANS=BUSY slot inside a burst
HADDR  out  32  AHB address
HTRANS  out  2  AHB transfer type
HWRITE  out  1  AHB direction
HSIZE  out  3  always 3'b010
HBURST  out  3  3'b000 SINGLE, 3'b011 INCR4
HWDATA  out  32  AHB write data
HRDATA  in  32  AHB read data
HREADY  in  1  slave ready
HRESP  in  1  0 OKAY, 1 ERROR
RDATA  out  128  captured read line, same beat packing as CMD_WDATA
DONE  out  1  one-cycle pulse: command finished
ERR  out  1  valid with DONE; 1 = command aborted on ERROR

Behaviour:
- Reset (HRESET=1 at a rising edge): state IDLE; HTRANS=IDLE; HADDR, HWDATA, RDATA, counters = 0; HWRITE=0; HBURST=0; DONE=0; ERR=0. Reset mid-transfer abandons the command with no DONE.
- States: IDLE, ADDR, LAST_DATA, ERR2.
- IDLE: CMD_READY=1. If CMD_VALID is high, latch BURST, WRITE and WDATA, then go to ADDR.
- Address alignment: SINGLE forces ADDR[1:0]=0. INCR4 forces ADDR[3:0]=0, so a burst never crosses a 1KB boundary.
- ADDR: the first beat drives HTRANS=NONSEQ; later beats drive SEQ; HADDR = start + 4*addr_cnt.
- All address/control outputs hold while HREADY=0. They advance only on a rising edge with HREADY=1.
- BUSY_IN is honoured only in ADDR, for a burst, after NONSEQ has been accepted, with beats remaining. It drives HTRANS=BUSY, holds HADDR at the next-beat address and does not advance addr_cnt. BUSY_IN is ignored for SINGLE, for NONSEQ and in LAST_DATA.
- Data-phase tracking: a dp_valid flag is set when an accepted address phase was NONSEQ or SEQ, and cleared for BUSY or IDLE.
  - Write data: HWDATA = line[data_cnt] during a valid write data phase.
  - Read data: on HREADY=1 with dp_valid and HRESP=0, HRDATA is stored into RDATA beat data_cnt and data_cnt is incremented.
- When the last address (addr_cnt = beats-1) is accepted, go to LAST_DATA with HTRANS=IDLE.
- LAST_DATA: when the final data phase completes (HREADY=1, HRESP=0), go to IDLE. DONE=1 and ERR=0 are registered for that next cycle.
- ERROR, first cycle (HRESP=1, HREADY=0): HTRANS=IDLE on the next edge, cancelling any pending address; go to ERR2.
- ERR2: on HREADY=1, go to IDLE with DONE=1, ERR=1. RDATA beats not completed keep their previous value.
- Latency from the accept edge to DONE, with no wait states:
  - SINGLE: DONE is high 3 cycles later.
  - INCR4: DONE is high 6 cycles later.
  - Each wait state or BUSY slot adds 1 cycle.
- A new command is accepted in the same cycle DONE is high.
- Counters are 3 bits and never wrap: addr_cnt ≤ beats, data_cnt ≤ beats.

Decomposition:
- Package ahb_pkg:
  - HTRANS codes: IDLE 00, BUSY 01, NONSEQ 10, SEQ 11.
  - HBURST codes: SINGLE 000, INCR4 011.
  - HSIZE_WORD 010.
  - State enum.
  - Decoder opcodes: 100011, 101011, 100001, 100000, 000000.
- One sub-module, ahb_line_buffer: 4x32 write-line latch plus read-capture registers, indexed by data_cnt.

Test Plan:
- SINGLE write, A=0x100, W0=0xDEADBEEF, HREADY=1 → cycle1 NONSEQ/0x100/HWRITE=1; cycle2 HWDATA=0xDEADBEEF; cycle3 DONE=1, ERR=0.
- INCR4 read, A=0x204 → HADDR 0x200, 204, 208, 20C; HTRANS NONSEQ, SEQ, SEQ, SEQ; HRDATA 1,2,3,4 → RDATA=0x00000004_00000003_00000002_00000001; DONE 6 cycles after accept.
- INCR4 write with HREADY=0 for 2 cycles on beat 1 → HADDR/HTRANS/HWDATA held stable; DONE at cycle 8.
- INCR4 read with BUSY_IN=1 for one cycle after NONSEQ accepted → one HTRANS=BUSY at 0x304, beat not counted; 4 beats captured; DONE at cycle 7.
- INCR4 write with ERROR on beat 2 (HREADY=0, HRESP=1, then HREADY=1, HRESP=1) → HTRANS=IDLE the cycle after the first ERROR cycle; no SEQ to 0x40C; DONE=1, ERR=1.
- HRESET asserted mid-burst → next cycle HTRANS=IDLE, CMD_READY=1, DONE=0; the following command proceeds normally.
